// File: rtl/ahb_sram_slave_if.sv
// AHB-lite bus bundle between a master/interconnect and the SRAM slave.
// HREADY is the interconnect's combined ready, so it is driven from the master side.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB slave serving a word-organised SRAM with optional wait states,
// selectable byte-lane order and a two-cycle ERROR response for illegal accesses.
module ahb_sram_slave #(
  parameter int unsigned ADDR_WDT    = 10,
  parameter int unsigned WAIT_STATES = 0,
  parameter bit          BIG_ENDIAN  = 1'b1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_sram_slave_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WDT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_WDT-1:0] idx_q, idx_d;
  logic [1:0]          off_q, off_d;
  logic [2:0]          size_q, size_d;
  logic                write_q, write_d;

  logic [31:0] mem [DEPTH];

  logic       accept;
  logic       illegal;
  logic       commit;
  logic [3:0] lane_mask;
  logic [3:0] be;

  // Bits the slave deliberately ignores: burst type, protection, upper address, HTRANS[0].
  logic unused_bits;
  assign unused_bits = ^{bus.HBURST, bus.HPROT, bus.HADDR[31:ADDR_WDT+2], bus.HTRANS[0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;

    illegal = (bus.HSIZE > 3'b010) ||
              ((bus.HSIZE == 3'b001) && bus.HADDR[0]) ||
              ((bus.HSIZE == 3'b010) && (bus.HADDR[1:0] != 2'b00));

    // Only ready states may take a new address phase, so a stray HREADY=1
    // during WAIT/ERR1 cannot corrupt the transfer in flight.
    accept = ((state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2)) &&
             bus.HSEL && bus.HREADY && bus.HTRANS[1];

    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept) begin
          idx_d   = bus.HADDR[ADDR_WDT+1:2];
          off_d   = bus.HADDR[1:0];
          size_d  = bus.HSIZE;
          write_d = bus.HWRITE;
          if (illegal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = 2'b00;
    bus.HRDATA    = '0;
    commit        = 1'b0;

    case (state_q)
      ST_WAIT: bus.HREADYOUT = 1'b0;
      ST_DATA: begin
        commit = write_q;
        if (!write_q) begin
          bus.HRDATA = mem[idx_q];
        end
      end
      ST_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = 2'b01;
      end
      ST_ERR2: bus.HRESP = 2'b01;
      default: ;
    endcase

    // lane_mask is indexed by byte offset; be is indexed by physical lane.
    case (size_q)
      3'b000:  lane_mask = 4'b0001 << off_q;
      3'b001:  lane_mask = off_q[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
    for (int unsigned i = 0; i < 4; i++) begin
      be[i] = BIG_ENDIAN ? lane_mask[3-i] : lane_mask[i];
    end
  end

  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: three instances (0 waits BE, 3 waits BE,
// 0 waits LE) driven by one pipelined master model, one slave selected at a time.
module tb_ahb_sram_slave;

  logic        clk;
  logic        rst_n;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  int          sel;

  logic        hro_a    [3];
  logic [1:0]  hresp_a  [3];
  logic [31:0] hrdata_a [3];
  logic        hro;
  logic [1:0]  hresp_o;
  logic [31:0] hrdata_o;

  typedef struct {
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int unsigned waits;
  } exp_t;

  exp_t        q[$];
  int unsigned cur_waits;
  int          n_cmp;
  int          n_err;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_sram_slave_if bus ();
    assign bus.HSEL   = hsel && (sel == g);
    assign bus.HADDR  = haddr;
    assign bus.HTRANS = htrans;
    assign bus.HWRITE = hwrite;
    assign bus.HSIZE  = hsize;
    assign bus.HBURST = 3'b000;
    assign bus.HPROT  = 4'b0011;
    assign bus.HWDATA = hwdata;
    assign bus.HREADY = bus.HREADYOUT;
    assign hro_a[g]    = bus.HREADYOUT;
    assign hresp_a[g]  = bus.HRESP;
    assign hrdata_a[g] = bus.HRDATA;

    ahb_sram_slave #(
      .ADDR_WDT    (10),
      .WAIT_STATES ((g == 1) ? 3 : 0),
      .BIG_ENDIAN  ((g == 2) ? 1'b0 : 1'b1)
    ) u_dut (
      .HCLK    (clk),
      .HRESETn (rst_n),
      .bus     (bus)
    );
  end

  always_comb begin
    hro      = hro_a[sel];
    hresp_o  = hresp_a[sel];
    hrdata_o = hrdata_a[sel];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t sel=%0d)", tag, act, exp, $time, sel);
    end
  endtask

  // Sample at the falling edge: check the data phase in flight, report readiness.
  task automatic observe(output logic rdy);
    exp_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      if (!hro) begin
        chk("resp_wait", {30'b0, hresp_o}, {31'b0, q[0].err});
        cur_waits++;
        rdy = 1'b0;
      end else begin
        e = q.pop_front();
        chk("resp", {30'b0, hresp_o}, {31'b0, e.err});
        chk("waits", cur_waits, e.waits);
        if (!e.wr && !e.err) chk("rdata", hrdata_o, e.rdata);
        else                 chk("rdata_zero", hrdata_o, 32'h0);
        cur_waits = 0;
        rdy = 1'b1;
      end
    end else begin
      chk("idle_rdy", {31'b0, hro}, 32'd1);
      chk("idle_resp", {30'b0, hresp_o}, 32'd0);
      chk("idle_rdata", hrdata_o, 32'h0);
      rdy = hro;
    end
  endtask

  task automatic beat(input logic hs, input logic [1:0] tr, input logic wr,
                      input logic [2:0] sz, input logic [31:0] ad,
                      input logic [31:0] wd, input logic [31:0] rd, input logic er);
    logic rdy;
    logic done;
    exp_t e;
    done   = 1'b0;
    hsel   = hs;
    htrans = tr;
    hwrite = wr;
    hsize  = sz;
    haddr  = ad;
    for (int n = 0; n < 40 && !done; n++) begin
      observe(rdy);
      if (rdy) begin
        if (hs && tr[1]) begin
          e.wr    = wr;
          e.wdata = wd;
          e.rdata = rd;
          e.err   = er;
          e.waits = er ? 1 : ((sel == 1) ? 3 : 0);
          q.push_back(e);
        end
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      hwdata = (q.size() > 0) ? q[0].wdata : 32'h0;
    end
    chk("accept_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic flush();
    for (int n = 0; n < 10 && q.size() > 0; n++) begin
      beat(1'b0, T_IDLE, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0);
    end
    chk("flush", q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    cur_waits = 0;
    sel       = 0;
    rst_n     = 1'b0;
    hsel      = 1'b0;
    htrans    = T_IDLE;
    hwrite    = 1'b0;
    hsize     = 3'b010;
    haddr     = 32'h0;
    hwdata    = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rdy", {31'b0, hro}, 32'd1);
    chk("reset_resp", {30'b0, hresp_o}, 32'd0);
    chk("reset_rdata", hrdata_o, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Word write then pipelined read of the same word, plus aliased read.
    beat(1'b1, T_NSEQ, 1'b1, 3'b010, 32'h4000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
    beat(1'b1, T_NSEQ, 1'b0, 3'b010, 32'h4000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    beat(1'b1, T_NSEQ, 1'b0, 3'b010, 32'h4000_1010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    flush();

    // Big-endian byte and half writes into a preset word.
    beat(1'b1, T_NSEQ, 1'b1, 3'b010, 32'h4000_0020, 32'h1122_3344, 32'h0, 1'b0);
    beat(1'b1, T_NSEQ, 1'b1, 3'b000, 32'h4000_0021, 32'h00AA_0000, 32'h0, 1'b0);
    beat(1'b1, T_NSEQ, 1'b0, 3'b010, 32'h4000_0020, 32'h0, 32'h11AA_3344, 1'b0);
    beat(1'b1, T_NSEQ, 1'b1, 3'b001, 32'h4000_0022, 32'h0000_BEEF, 32'h0, 1'b0);
    beat(1'b1, T_NSEQ, 1'b0, 3'b010, 32'h4000_0020, 32'h0, 32'h11AA_BEEF, 1'b0);
    flush();

    // Illegal accesses: misaligned word read, oversize read, misaligned word and half writes.
    beat(1'b1, T_NSEQ, 1'b0, 3'b010, 32'h4000_0002, 32'h0, 32'h0, 1'b1);
    beat(1'b1, T_NSEQ, 1'b0, 3'b011, 32'h4000_0020, 32'h0, 32'h0, 1'b1);
    beat(1'b1, T_NSEQ, 1'b1, 3'b010, 32'h4000_0021, 32'hFFFF_FFFF, 32'h0, 1'b1);
    beat(1'b1, T_NSEQ, 1'b1, 3'b001, 32'h4000_0023, 32'hFFFF_FFFF, 32'h0, 1'b1);
    beat(1'b1, T_NSEQ, 1'b0, 3'b010, 32'h4000_0020, 32'h0, 32'h11AA_BEEF, 1'b0);
    flush();

    // Little-endian lane order.
    sel = 2;
    beat(1'b1, T_NSEQ, 1'b1, 3'b010, 32'h4000_0020, 32'h1122_3344, 32'h0, 1'b0);
    beat(1'b1, T_NSEQ, 1'b1, 3'b000, 32'h4000_0021, 32'h0000_AA00, 32'h0, 1'b0);
    beat(1'b1, T_NSEQ, 1'b0, 3'b010, 32'h4000_0020, 32'h0, 32'h1122_AA44, 1'b0);
    flush();

    // Three wait states, back-to-back write then read.
    sel = 1;
    beat(1'b1, T_NSEQ, 1'b1, 3'b010, 32'h4000_0030, 32'hA5A5_5A5A, 32'h0, 1'b0);
    beat(1'b1, T_NSEQ, 1'b0, 3'b010, 32'h4000_0030, 32'h0, 32'hA5A5_5A5A, 1'b0);
    beat(1'b1, T_NSEQ, 1'b1, 3'b010, 32'h4000_0040, 32'h1234_5678, 32'h0, 1'b0);
    flush();

    // Reset asserted during the WAIT of a write: outputs clear at once, write is lost.
    hsel   = 1'b1;
    htrans = T_NSEQ;
    hwrite = 1'b1;
    hsize  = 3'b010;
    haddr  = 32'h4000_0040;
    @(negedge clk);
    chk("rst_pre_rdy", {31'b0, hro}, 32'd1);
    @(posedge clk);
    #1;
    hsel   = 1'b0;
    htrans = T_IDLE;
    hwdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rst_wait_rdy", {31'b0, hro}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rdy", {31'b0, hro}, 32'd1);
    chk("rst_mid_resp", {30'b0, hresp_o}, 32'd0);
    chk("rst_mid_rdata", hrdata_o, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    cur_waits = 0;
    @(posedge clk);
    #1;
    hwdata = 32'h0;
    beat(1'b1, T_NSEQ, 1'b0, 3'b010, 32'h4000_0040, 32'h0, 32'h1234_5678, 1'b0);
    flush();

    // BUSY and IDLE with HSEL=1 interleaved with SEQ beats.
    sel = 0;
    beat(1'b1, T_NSEQ, 1'b1, 3'b010, 32'h4000_0050, 32'h0101_0101, 32'h0, 1'b0);
    beat(1'b1, T_SEQ,  1'b1, 3'b010, 32'h4000_0054, 32'h0202_0202, 32'h0, 1'b0);
    beat(1'b1, T_BUSY, 1'b1, 3'b010, 32'h4000_0058, 32'hFFFF_FFFF, 32'h0, 1'b0);
    beat(1'b1, T_IDLE, 1'b1, 3'b010, 32'h4000_0058, 32'hFFFF_FFFF, 32'h0, 1'b0);
    beat(1'b1, T_SEQ,  1'b1, 3'b010, 32'h4000_0058, 32'h0303_0303, 32'h0, 1'b0);
    beat(1'b1, T_NSEQ, 1'b0, 3'b010, 32'h4000_0050, 32'h0, 32'h0101_0101, 1'b0);
    beat(1'b1, T_SEQ,  1'b0, 3'b010, 32'h4000_0054, 32'h0, 32'h0202_0202, 1'b0);
    beat(1'b1, T_BUSY, 1'b0, 3'b010, 32'h4000_0058, 32'h0, 32'h0, 1'b0);
    beat(1'b1, T_IDLE, 1'b0, 3'b010, 32'h4000_0058, 32'h0, 32'h0, 1'b0);
    beat(1'b1, T_SEQ,  1'b0, 3'b010, 32'h4000_0058, 32'h0, 32'h0303_0303, 1'b0);
    flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB slave that serves a word-organised on-chip SRAM on the GRLIB AMBA bus.
- It is the responder counterpart to the PicoRV32 AHB master: it gives the RISC-V core a program/data memory at the address range assigned by the bus decoder (for example, the reset vector region 0x4000_0000).
- It supports configurable wait states, big- or little-endian byte lanes, and a two-cycle ERROR response for illegal accesses.

Parameters:
- ADDR_WDT, 10, word-index width; memory depth = 2^ADDR_WDT 32-bit words (default 4 KiB).
- WAIT_STATES, 0, number of HREADYOUT-low cycles inserted in every OKAY data phase (0..15).
- BIG_ENDIAN, 1, 1 = GRLIB lane order (byte offset 0 on HWDATA/HRDATA[31:24]); 0 = offset 0 on [7:0].

Ports:
- HCLK  in  1  bus clock; all logic is on the rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from the bus decoder.
- HADDR  in  32  address; bits [ADDR_WDT+1:2] index the memory, higher bits are ignored.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 byte, 001 half, 010 word; larger values are illegal.
- HBURST  in  3  ignored; each beat is handled independently.
- HPROT  in  4  ignored.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-wide ready; an address phase is sampled only when HREADY=1.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  2  00 OKAY, 01 ERROR; RETRY and SPLIT are never issued.
- HRDATA  out  32  read data.

Behaviour:
- Reset (asynchronous, HRESETn=0):
  - HREADYOUT=1, HRESP=00, HRDATA=0, state=IDLE, wait counter=0.
  - Memory contents are not reset.
  - A reset asserted mid-transfer aborts it; a pending write is not committed.
- Transfer acceptance: a transfer is accepted at a rising edge with HSEL=1, HREADY=1 and HTRANS[1]=1.
  - On acceptance, latch index=HADDR[ADDR_WDT+1:2], offset=HADDR[1:0], HSIZE and HWRITE.
  - IDLE or BUSY with HSEL=1, or any cycle with HSEL=0, gives a zero-wait OKAY: HREADYOUT=1, HRESP=00.
- Illegal access, when either holds:
  - HSIZE>010.
  - Misalignment: half with HADDR[0]=1, or word with HADDR[1:0]!=00.
- States:
  - IDLE: HREADYOUT=1, HRESP=00.
    - Accepted illegal transfer → ERR1.
    - Accepted legal transfer with WAIT_STATES>0 → WAIT, counter=WAIT_STATES-1.
    - Accepted legal transfer with WAIT_STATES=0 → DATA.
  - WAIT: HREADYOUT=0, HRESP=00; counter decrements; at counter=0 → DATA.
  - DATA: HREADYOUT=1, HRESP=00; the transfer completes this cycle.
    - Pipelined acceptance of the next transfer → IDLE rules applied immediately: next state is WAIT, DATA or ERR1.
    - Otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=01; no acceptance (HREADY is low); → ERR2.
  - ERR2: HREADYOUT=1, HRESP=01; acceptance is allowed, with the same next-state rules as DATA.
  - An erroring transfer never writes memory.
- Write commit: at the rising edge ending DATA.
  - Byte enables: byte → 1 lane selected by offset; half → 2 lanes selected by offset[1]; word → all 4 lanes.
  - Lane mapping follows BIG_ENDIAN; HWDATA is sampled on that edge.
- Read data:
  - During DATA of a read, HRDATA is the full 32-bit word at the latched index, combinational from the array; the master selects the bytes.
  - HRDATA=0 in every other state and for writes.
  - A read whose address phase overlaps the preceding write's DATA cycle to the same word returns the newly written value: the commit edge precedes the read DATA cycle.
- Address wrap: indices beyond the depth alias modulo 2^ADDR_WDT. There is no error for out-of-range addresses; range decode is done by HSEL.
- Simultaneous events: HSEL deasserting during WAIT does not abort the current data phase.

Test Plan:
- Reset, defaults, WAIT_STATES=0, BIG_ENDIAN=1:
  - Word write 0xDEADBEEF to 0x4000_0010, then word read of 0x4000_0010.
  - Required: read DATA cycle gives HRDATA=0xDEADBEEF, HRESP=00, no HREADYOUT low cycles.
- Byte write 0xAA (HWDATA=0x00AA0000) to offset 01 of a word preset to 0x11223344, then word read.
  - Required: 0x11AA3344.
  - With BIG_ENDIAN=0, HWDATA=0x0000AA00 gives 0x1122AA44.
- Word read at 0x4000_0002:
  - Required: ERR1 (HREADYOUT=0, HRESP=01), then ERR2 (HREADYOUT=1, HRESP=01), then OKAY.
  - Memory is unchanged.
  - Repeat with HSIZE=011: same response.
- WAIT_STATES=3, back-to-back NONSEQ write then read to the same word:
  - Required: each data phase shows exactly 3 HREADYOUT=0 cycles, then 1 ready cycle.
  - The read returns the written value.
- HRESETn pulsed low during the WAIT of a write:
  - Required: outputs return to reset values immediately.
  - A later read shows the old word contents.
- HTRANS=BUSY and IDLE with HSEL=1, interleaved with SEQ beats:
  - Required: BUSY/IDLE get zero-wait OKAY with no memory access.
  - The SEQ beats complete normally.
